nts_dispatcher: RTL and testbench

//  Receive side of the dispatch interface: takes 64-bit RX frames from the MAC and buffers them in two
//  on-chip banks (ping-pong). Presents one complete packet at a time to nts_engine as a

---
 rtl/nts_dispatcher_pkg.sv | 7 +
 rtl/nts_dispatcher_bram.sv | 23 ++
 rtl/nts_dispatcher.sv | 137 +++++++++++++
 tb/tb_nts_dispatcher.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/nts_dispatcher_pkg.sv
// nts_dispatcher_pkg: shared constants and state encodings for the RX dispatcher
package nts_dispatcher_pkg;
    localparam logic [7:0] MASK_NONE = 8'h00;
    localparam int NBANKS = 2;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_PREFETCH, R_AVAIL} r_state_e;
endpackage

// File: rtl/nts_dispatcher_bram.sv
// nts_dispatcher_bram: simple dual-port RAM with registered read, MSB of address selects bank
module nts_dispatcher_bram #(
    parameter int AW = 11,
    parameter int DW = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rdata_o <= '0;
        else if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/nts_dispatcher.sv
// nts_dispatcher: ping-pong buffers MAC RX frames and presents one packet at a time
// to the engine as a FWFT FIFO with an available/discard handshake.
module nts_dispatcher
    import nts_dispatcher_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [7:0]            i_rx_data_valid,
    input  logic [63:0]           i_rx_data,
    input  logic                  i_rx_good_frame,
    input  logic                  i_rx_bad_frame,
    output logic                  o_dispatch_packet_available,
    input  logic                  i_dispatch_packet_read_discard,
    output logic [7:0]            o_dispatch_data_valid,
    output logic                  o_dispatch_fifo_empty,
    input  logic                  i_dispatch_fifo_rd_en,
    output logic [63:0]           o_dispatch_fifo_rd_data,
    output logic [ADDR_WIDTH-1:0] o_dispatch_counter,
    output logic [31:0]           o_frames_dropped
);
    localparam int AW = ADDR_WIDTH;
    w_state_e          w_state_q;
    r_state_e          r_state_q;
    logic [NBANKS-1:0] full_q;
    logic [AW-1:0]     cnt_q [NBANKS];
    logic [7:0]        mask_q [NBANKS];
    logic              wr_bank_q, rd_bank_q;
    logic [AW:0]       wr_cnt_q;
    logic [7:0]        last_mask_q;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic              avail_q, empty_q;
    logic [7:0]        dv_q;
    logic [AW-1:0]     ctr_q;
    logic [31:0]       drop_q;
    logic              word, end_any, discard, bank_free, we, re, pop, drop;

    assign word      = i_rx_data_valid != MASK_NONE;
    assign end_any   = i_rx_good_frame | i_rx_bad_frame;
    assign discard   = r_state_q == R_AVAIL && i_dispatch_packet_read_discard;
    // A bank released by discard this cycle may take the next frame immediately
    assign bank_free = !full_q[wr_bank_q] || (discard && rd_bank_q == wr_bank_q);
    assign we        = word && ((w_state_q == W_IDLE && bank_free) ||
                                (w_state_q == W_FILL && !end_any && !wr_cnt_q[AW]));
    assign drop      = (w_state_q == W_FILL && i_rx_bad_frame) || (w_state_q == W_DROP && end_any);
    assign pop       = r_state_q == R_AVAIL && !discard && i_dispatch_fifo_rd_en && !empty_q;
    assign re        = r_state_q == R_PREFETCH || (pop && rd_ptr_q != ctr_q);
    assign rd_ptr_d  = r_state_q == R_PREFETCH ? '0 : rd_ptr_q + 1'b1;

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            full_q      <= '0;
            cnt_q       <= '{default: '0};
            mask_q      <= '{default: '0};
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            last_mask_q <= '0;
            rd_ptr_q    <= '0;
            avail_q     <= 1'b0;
            empty_q     <= 1'b1;
            dv_q        <= '0;
            ctr_q       <= '0;
            drop_q      <= '0;
        end else begin
            if (drop) drop_q <= &drop_q ? drop_q : drop_q + 1'b1;
            if (re) rd_ptr_q <= rd_ptr_d;
            unique case (r_state_q)
                R_IDLE: if (full_q[rd_bank_q]) r_state_q <= R_PREFETCH;
                R_PREFETCH: begin
                    r_state_q <= R_AVAIL;
                    avail_q   <= 1'b1;
                    empty_q   <= 1'b0;
                    dv_q      <= mask_q[rd_bank_q];
                    ctr_q     <= cnt_q[rd_bank_q];
                end
                R_AVAIL: begin
                    if (discard) begin
                        r_state_q         <= R_IDLE;
                        avail_q           <= 1'b0;
                        empty_q           <= 1'b1;
                        full_q[rd_bank_q] <= 1'b0;
                        rd_bank_q         <= !rd_bank_q;
                    end else if (pop && rd_ptr_q == ctr_q) empty_q <= 1'b1;
                end
                default: r_state_q <= R_IDLE;
            endcase
            unique case (w_state_q)
                W_IDLE: if (word) begin
                    w_state_q   <= bank_free ? W_FILL : W_DROP;
                    wr_cnt_q    <= (AW+1)'(1);
                    last_mask_q <= i_rx_data_valid;
                end
                W_FILL: begin
                    if (end_any) begin
                        w_state_q <= W_IDLE;
                        if (!i_rx_bad_frame) begin
                            full_q[wr_bank_q] <= 1'b1;
                            cnt_q[wr_bank_q]  <= AW'(wr_cnt_q - 1'b1);
                            mask_q[wr_bank_q] <= last_mask_q;
                            wr_bank_q         <= !wr_bank_q;
                        end
                    end else if (word) begin
                        // Bank already holds 2**AW words: frame cannot fit
                        if (wr_cnt_q[AW]) w_state_q <= W_DROP;
                        else begin
                            wr_cnt_q    <= wr_cnt_q + 1'b1;
                            last_mask_q <= i_rx_data_valid;
                        end
                    end
                end
                W_DROP: if (end_any) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    nts_dispatcher_bram #(.AW(AW + 1), .DW(64)) u_bram (
        .clk_i   (i_clk),
        .rst_i   (i_areset),
        .we_i    (we),
        .waddr_i ({wr_bank_q, w_state_q == W_IDLE ? {AW{1'b0}} : wr_cnt_q[AW-1:0]}),
        .wdata_i (i_rx_data),
        .re_i    (re),
        .raddr_i ({rd_bank_q, rd_ptr_d}),
        .rdata_o (o_dispatch_fifo_rd_data)
    );

    assign o_dispatch_packet_available = avail_q;
    assign o_dispatch_fifo_empty       = empty_q;
    assign o_dispatch_data_valid       = dv_q;
    assign o_dispatch_counter          = ctr_q;
    assign o_frames_dropped            = drop_q;
endmodule

// File: tb/tb_nts_dispatcher.sv
// tb_nts_dispatcher: scoreboard bench for nts_dispatcher; frames kept by the DUT are
// queued as they are sent and compared word by word as the engine side reads them.
module tb_nts_dispatcher;
    localparam int AW = 10;
    logic          i_clk = 1'b0;
    logic          i_areset = 1'b1;
    logic [7:0]    i_rx_data_valid = '0;
    logic [63:0]   i_rx_data = '0;
    logic          i_rx_good_frame = 1'b0;
    logic          i_rx_bad_frame = 1'b0;
    logic          o_dispatch_packet_available;
    logic          i_dispatch_packet_read_discard = 1'b0;
    logic [7:0]    o_dispatch_data_valid;
    logic          o_dispatch_fifo_empty;
    logic          i_dispatch_fifo_rd_en = 1'b0;
    logic [63:0]   o_dispatch_fifo_rd_data;
    logic [AW-1:0] o_dispatch_counter;
    logic [31:0]   o_frames_dropped;

    int checks = 0, failures = 0, exp_drop = 0, lat;
    logic [63:0] exp_w[$];
    int          exp_n[$];
    logic [7:0]  exp_m[$];

    nts_dispatcher #(.ADDR_WIDTH(AW)) dut (
        .i_clk                          (i_clk),
        .i_areset                       (i_areset),
        .i_rx_data_valid                (i_rx_data_valid),
        .i_rx_data                      (i_rx_data),
        .i_rx_good_frame                (i_rx_good_frame),
        .i_rx_bad_frame                 (i_rx_bad_frame),
        .o_dispatch_packet_available    (o_dispatch_packet_available),
        .i_dispatch_packet_read_discard (i_dispatch_packet_read_discard),
        .o_dispatch_data_valid          (o_dispatch_data_valid),
        .o_dispatch_fifo_empty          (o_dispatch_fifo_empty),
        .i_dispatch_fifo_rd_en          (i_dispatch_fifo_rd_en),
        .o_dispatch_fifo_rd_data        (o_dispatch_fifo_rd_data),
        .o_dispatch_counter             (o_dispatch_counter),
        .o_frames_dropped               (o_frames_dropped)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_avail"}, o_dispatch_packet_available, 0);
        chk({tag, "_empty"}, o_dispatch_fifo_empty, 1);
        chk({tag, "_dv"}, o_dispatch_data_valid, 0);
        chk({tag, "_rdata"}, o_dispatch_fifo_rd_data, 0);
        chk({tag, "_ctr"}, o_dispatch_counter, 0);
        chk({tag, "_drop"}, o_frames_dropped, 0);
    endtask

    task automatic send(input int n, input logic [7:0] m, input bit good, input bit bad, input bit keep);
        logic [63:0] w;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            w = {$urandom, $urandom};
            i_rx_data_valid = (i == n - 1) ? m : 8'hff;
            i_rx_data = w;
            if (keep) exp_w.push_back(w);
        end
        @(negedge i_clk);
        i_rx_data_valid = '0;
        i_rx_good_frame = good;
        i_rx_bad_frame = bad;
        @(negedge i_clk);
        i_rx_good_frame = 1'b0;
        i_rx_bad_frame = 1'b0;
        if (keep) begin
            exp_n.push_back(n);
            exp_m.push_back(m);
        end else exp_drop++;
    endtask

    task automatic wait_avail(output int waits);
        waits = 0;
        while (!o_dispatch_packet_available && waits < 8) begin
            @(negedge i_clk);
            waits++;
        end
        chk("avail", o_dispatch_packet_available, 1);
    endtask

    task automatic read_pkt(input int npop);
        int n, w;
        logic [7:0] m;
        logic [63:0] ew;
        wait_avail(w);
        n = exp_n.pop_front();
        m = exp_m.pop_front();
        chk("counter", o_dispatch_counter, 64'(n - 1));
        chk("data_valid", o_dispatch_data_valid, m);
        for (int i = 0; i < n; i++) begin
            ew = exp_w.pop_front();
            if (i < npop) begin
                chk("not_empty", o_dispatch_fifo_empty, 0);
                chk("rd_data", o_dispatch_fifo_rd_data, ew);
                chk("ctr_stable", o_dispatch_counter, 64'(n - 1));
                i_dispatch_fifo_rd_en = 1'b1;
                @(negedge i_clk);
                i_dispatch_fifo_rd_en = 1'b0;
            end
        end
        if (npop == n) begin
            chk("empty_end", o_dispatch_fifo_empty, 1);
            chk("avail_hold", o_dispatch_packet_available, 1);
            i_dispatch_fifo_rd_en = 1'b1;
            @(negedge i_clk);
            i_dispatch_fifo_rd_en = 1'b0;
            chk("empty_stay", o_dispatch_fifo_empty, 1);
            chk("dv_stable", o_dispatch_data_valid, m);
        end
        i_dispatch_packet_read_discard = 1'b1;
        @(negedge i_clk);
        i_dispatch_packet_read_discard = 1'b0;
        chk("avail_off", o_dispatch_packet_available, 0);
        chk("empty_off", o_dispatch_fifo_empty, 1);
    endtask

    task automatic reset_now(input string tag);
        #2 i_areset = 1'b1;
        i_rx_data_valid = '0;
        i_dispatch_fifo_rd_en = 1'b0;
        #1 chk_reset(tag);
        @(negedge i_clk);
        i_areset = 1'b0;
        exp_w.delete();
        exp_n.delete();
        exp_m.delete();
        exp_drop = 0;
    endtask

    initial begin
        @(negedge i_clk);
        chk_reset("rst");
        @(negedge i_clk);
        i_areset = 1'b0;
        // discard with nothing available must not move the read bank
        i_dispatch_packet_read_discard = 1'b1;
        @(negedge i_clk);
        i_dispatch_packet_read_discard = 1'b0;
        chk("idle_discard", o_dispatch_packet_available, 0);

        send(3, 8'h0f, 1, 0, 1);
        wait_avail(lat);
        chk("latency_le3", 64'(lat <= 3), 1);
        read_pkt(3);

        send(5, 8'hff, 0, 1, 0);
        repeat (4) @(negedge i_clk);
        chk("bad_no_avail", o_dispatch_packet_available, 0);
        chk("bad_drop", o_frames_dropped, 64'(exp_drop));
        send(2, 8'hff, 1, 1, 0);
        repeat (4) @(negedge i_clk);
        chk("goodbad_drop", o_frames_dropped, 64'(exp_drop));
        chk("goodbad_no_avail", o_dispatch_packet_available, 0);

        send(2, 8'h03, 1, 0, 1);
        send(3, 8'h7f, 1, 0, 1);
        send(4, 8'hff, 1, 0, 0);
        chk("both_full_drop", o_frames_dropped, 64'(exp_drop));
        read_pkt(2);
        read_pkt(3);

        send(2**AW + 1, 8'hff, 1, 0, 0);
        chk("overflow_drop", o_frames_dropped, 64'(exp_drop));
        send(1, 8'hff, 1, 0, 1);
        read_pkt(1);

        send(2**AW, 8'h01, 1, 0, 1);
        read_pkt(2**AW);

        send(4, 8'h3f, 1, 0, 1);
        send(2, 8'h01, 1, 0, 1);
        read_pkt(1);
        read_pkt(2);
        chk("drop_total", o_frames_dropped, 64'(exp_drop));

        @(negedge i_clk);
        i_rx_data_valid = 8'hff;
        i_rx_data = 64'h1111;
        @(negedge i_clk);
        i_rx_data = 64'h2222;
        reset_now("rst_fill");
        send(3, 8'h1f, 1, 0, 1);
        wait_avail(lat);
        chk("rd0_after_fill_rst", o_dispatch_fifo_rd_data, exp_w[0]);
        i_dispatch_fifo_rd_en = 1'b1;
        @(negedge i_clk);
        i_dispatch_fifo_rd_en = 1'b0;
        reset_now("rst_read");
        send(2, 8'h07, 1, 0, 1);
        read_pkt(2);
        chk("drop_after_rst", o_frames_dropped, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
